codec_init_sequencer: RTL and testbench
=======================================

# codec_init_sequencer

Sequences the audio codec's power-up configuration by walking a fixed table of 12 WM8731 register writes and issuing each one to the I2C master over a start/done handshake. It sits between the APU's I2C master and top-level control. It starts automatically after reset and can be re-run by a one-shot request. It reports progress as a step index for the seven-segment displays, and reports completion and failure flags.

## Interface
- `MAIN_CLK_SPEED`, 32'd50_000_000, system clock frequency in Hz; informational only.
- `DEV_ADDR`, 7'h1A, 7-bit codec I2C address.
- `GAP_CYCLES`, 16'd5000, idle cycles after every completed write attempt.
- `WATCHDOG_CYCLES`, 20'd500_000, maximum cycles to wait for `i2c_done`.
- `MAX_RETRIES`, 2'd3, retries per entry after a failed attempt.

Ports:
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle re-run request; honoured only in DONE or ERROR.
- `i2c_busy` in 1: I2C master is mid-transaction.
- `i2c_done` in 1: one-cycle pulse marking the end of a transaction.
- `i2c_ack_err` in 1: NACK seen; sampled only on the `i2c_done` cycle.
- `i2c_start` out 1: one-cycle transaction request.
- `i2c_dev_addr` out 7: equals `DEV_ADDR`.
- `i2c_data` out 16: {reg_addr[6:0], reg_data[8:0]} of the current entry.
- `step` out 4: current table index, 0–11; reads 12 when DONE.
- `retry_cnt` out 2: retries used on the current entry.
- `busy` out 1: sequence in progress.
- `cfg_done` out 1: all 12 writes acknowledged.
- `cfg_error` out 1: an entry exhausted its retries.

## Operation
Table, in index order (`i2c_data` value):
- 0: 16'h1E00
- 1: 16'h0C10
- 2: 16'h0017
- 3: 16'h0217
- 4: 16'h0479
- 5: 16'h0679
- 6: 16'h0812
- 7: 16'h0A00
- 8: 16'h0E02
- 9: 16'h1000
- 10: 16'h1201 (activate)
- 11: 16'h0C00 (outputs on)

The table is a fixed ROM. Order is mandatory: reset first, activate after all configuration writes.

FSM states and transitions:
- **IDLE**: entered on reset; moves to ISSUE on the next cycle with idx=0, retry_cnt=0.
- **ISSUE**: waits for `i2c_busy`=0, then pulses `i2c_start` for exactly one cycle and moves to WAIT. The watchdog counter is cleared on entry to WAIT.
- **WAIT**:
  - On `i2c_done` with `i2c_ack_err`=0: the attempt succeeded.
  - On `i2c_done` with `i2c_ack_err`=1, or when the watchdog reaches `WATCHDOG_CYCLES`: the attempt failed.
  - Either outcome moves to GAP.
- **GAP**: counts `GAP_CYCLES`, then:
  - After success, idx=11: go to DONE.
  - After success, idx<11: idx+1, retry_cnt=0, go to ISSUE.
  - After failure, retry_cnt<`MAX_RETRIES`: retry_cnt+1, go to ISSUE with the same idx.
  - After failure, retry_cnt=`MAX_RETRIES`: go to ERROR.
- **DONE**: `cfg_done`=1 and `step`=12. `start` moves to ISSUE with idx=0 and retry_cnt=0, and clears `cfg_done`.
- **ERROR**: `cfg_error`=1; `step` and `retry_cnt` freeze at the failing entry. `start` restarts exactly as from DONE, and clears `cfg_error`.

Other rules:
- `start` in IDLE, ISSUE, WAIT or GAP is ignored.
- `i2c_done` outside WAIT is ignored.
- `i2c_data` and `i2c_dev_addr` hold stable from the `i2c_start` cycle until leaving GAP.
- `busy` = state is one of ISSUE, WAIT, GAP.
- Counters saturate and never wrap:
  - Gap counter: 16 bits.
  - Watchdog counter: 20 bits.
  - `retry_cnt`: never exceeds `MAX_RETRIES`.

## Timing
- Reset values (reset=0 at a `clk` edge): `i2c_start`=0, `i2c_data`=16'h1E00, `i2c_dev_addr`=`DEV_ADDR`, `step`=0, `retry_cnt`=0, `busy`=0, `cfg_done`=0, `cfg_error`=0.
- Reset asserted mid-transaction aborts immediately to IDLE. No stop or cleanup is issued; the I2C master is reset alongside this block.
- First `i2c_start` comes 2 cycles after the first edge with reset=1, provided `i2c_busy`=0: one cycle in IDLE, then the pulse in ISSUE.
- `i2c_done` in cycle N puts the FSM in GAP at N+1. The next `i2c_start` is at N+1+`GAP_CYCLES`+1.
- If `i2c_done` and watchdog expiry land in the same cycle, `i2c_done` and its `i2c_ack_err` decide the outcome.
- All outputs are registered; no combinational path from input to output.

## Test plan
Benches override `GAP_CYCLES`=4, `WATCHDOG_CYCLES`=64, `MAX_RETRIES`=3.

1. **Nominal run.** I2C model returns `i2c_done` 10 cycles after each start, with no NACK.
   - Required: 12 starts carrying the table values in order, consecutive starts 16 cycles apart.
   - Then `cfg_done`=1, `step`=12, `busy`=0.
2. **Single NACK.** NACK on the first attempt of idx 4.
   - Required: idx 4 (16'h0479) is reissued once, `retry_cnt` reads 1 during the reissue, and the sequence still finishes with `cfg_done`=1.
3. **Retries exhausted.** Every attempt at idx 7 NACKs.
   - Required: exactly 4 starts at 16'h0A00, then `cfg_error`=1, `step`=7, `retry_cnt`=3, and no further starts.
   - A following `start` pulse must restart at 16'h1E00.
4. **Watchdog.** `i2c_done` is never returned for idx 0.
   - Required: retry 64 cycles after the start (plus the gap), and ERROR after 4 attempts.
5. **Busy and ignored inputs.** Hold `i2c_busy`=1 for 20 cycles after reset; pulse `start` during WAIT; pulse a stray `i2c_done` during GAP.
   - Required: no `i2c_start` while busy, and no change to the sequence from the ignored pulses.
6. **Reset mid-run.** Assert reset during WAIT at idx 5.
   - Required: all outputs return to their reset values on the next edge, and after release the sequence restarts from 16'h1E00.

Source files
------------

// File: rtl/codec_init_sequencer_if.sv
// Handshake bundle between the codec init sequencer and the APU I2C master.
// The sequencer requests register writes; the I2C master reports busy/done/NACK.
interface codec_init_sequencer_if;
  logic        i2c_start;
  logic [6:0]  i2c_dev_addr;
  logic [15:0] i2c_data;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_ack_err;

  modport master (
    output i2c_start,
    output i2c_dev_addr,
    output i2c_data,
    input  i2c_busy,
    input  i2c_done,
    input  i2c_ack_err
  );

  modport slave (
    input  i2c_start,
    input  i2c_dev_addr,
    input  i2c_data,
    output i2c_busy,
    output i2c_done,
    output i2c_ack_err
  );
endinterface

// File: rtl/codec_init_sequencer.sv
// Walks the fixed WM8731 power-up table, issuing one I2C write per entry with
// watchdog, bounded retries and an inter-write gap; re-runnable via start.
module codec_init_sequencer #(
  parameter logic [31:0] MAIN_CLK_SPEED  = 32'd50_000_000,
  parameter logic [6:0]  DEV_ADDR        = 7'h1A,
  parameter logic [15:0] GAP_CYCLES      = 16'd5000,
  parameter logic [19:0] WATCHDOG_CYCLES = 20'd500_000,
  parameter logic [1:0]  MAX_RETRIES     = 2'd3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  codec_init_sequencer_if.master bus,
  output logic [3:0]             step,
  output logic [1:0]             retry_cnt,
  output logic                   busy,
  output logic                   cfg_done,
  output logic                   cfg_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [3:0] LAST_IDX  = 4'd11;
  localparam logic [3:0] DONE_STEP = 4'd12;

  if (MAIN_CLK_SPEED == 32'd0) begin : g_bad_clk
    $error("MAIN_CLK_SPEED must be nonzero");
  end

  // Register writes in mandatory order: reset first, activate near the end.
  function automatic logic [15:0] rom_entry(input logic [3:0] i);
    case (i)
      4'd0:    return 16'h1E00;
      4'd1:    return 16'h0C10;
      4'd2:    return 16'h0017;
      4'd3:    return 16'h0217;
      4'd4:    return 16'h0479;
      4'd5:    return 16'h0679;
      4'd6:    return 16'h0812;
      4'd7:    return 16'h0A00;
      4'd8:    return 16'h0E02;
      4'd9:    return 16'h1000;
      4'd10:   return 16'h1201;
      4'd11:   return 16'h0C00;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [19:0] sat_inc20(input logic [19:0] v);
    return (v == 20'hF_FFFF) ? v : v + 20'd1;
  endfunction

  state_t      state, state_d;
  logic [3:0]  idx, idx_d;
  logic [1:0]  retry_d;
  logic [15:0] gap_cnt, gap_d;
  logic [19:0] wd_cnt, wd_d;
  logic        ok, ok_d;
  logic        start_d;
  logic        gap_last;

  assign gap_last = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, GAP_CYCLES};
  assign bus.i2c_dev_addr = DEV_ADDR;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    retry_d = retry_cnt;
    gap_d   = gap_cnt;
    wd_d    = wd_cnt;
    ok_d    = ok;
    start_d = 1'b0;
    case (state)
      S_IDLE: begin
        state_d = S_ISSUE;
        idx_d   = 4'd0;
        retry_d = 2'd0;
      end
      S_ISSUE: begin
        if (!bus.i2c_busy) begin
          start_d = 1'b1;
          wd_d    = 20'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done pulse wins over a watchdog expiry landing in the same cycle.
        if (bus.i2c_done) begin
          ok_d    = !bus.i2c_ack_err;
          gap_d   = 16'd0;
          state_d = S_GAP;
        end else if (wd_cnt >= WATCHDOG_CYCLES) begin
          ok_d    = 1'b0;
          gap_d   = 16'd0;
          state_d = S_GAP;
        end else begin
          wd_d = sat_inc20(wd_cnt);
        end
      end
      S_GAP: begin
        if (!gap_last) begin
          gap_d = sat_inc16(gap_cnt);
        end else if (ok) begin
          if (idx == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx + 4'd1;
            retry_d = 2'd0;
            state_d = S_ISSUE;
          end
        end else if (retry_cnt < MAX_RETRIES) begin
          retry_d = retry_cnt + 2'd1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          idx_d   = 4'd0;
          retry_d = 2'd0;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      idx           <= 4'd0;
      retry_cnt     <= 2'd0;
      gap_cnt       <= 16'd0;
      wd_cnt        <= 20'd0;
      ok            <= 1'b0;
      bus.i2c_start <= 1'b0;
      bus.i2c_data  <= rom_entry(4'd0);
      step          <= 4'd0;
      busy          <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_error     <= 1'b0;
    end else begin
      state         <= state_d;
      idx           <= idx_d;
      retry_cnt     <= retry_d;
      gap_cnt       <= gap_d;
      wd_cnt        <= wd_d;
      ok            <= ok_d;
      bus.i2c_start <= start_d;
      bus.i2c_data  <= rom_entry(idx_d);
      step          <= (state_d == S_DONE) ? DONE_STEP : idx_d;
      busy          <= (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_GAP);
      cfg_done      <= (state_d == S_DONE);
      cfg_error     <= (state_d == S_ERROR);
    end
  end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: an I2C responder driven by per-entry fault
// policies, and a transaction-level model predicting every start cycle.
module tb_codec_init_sequencer;
  localparam int GAP  = 4;
  localparam int WD   = 64;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] step;
  logic [1:0] retry_cnt;
  logic       busy, cfg_done, cfg_error;

  codec_init_sequencer_if bus();

  codec_init_sequencer #(
    .GAP_CYCLES(16'd4),
    .WATCHDOG_CYCLES(20'd64),
    .MAX_RETRIES(2'd3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus.master),
    .step(step),
    .retry_cnt(retry_cnt),
    .busy(busy),
    .cfg_done(cfg_done),
    .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [12] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                            16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201, 16'h0C00};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat = 10;
  int fails [12];
  bit silent [12];
  int attempts [12];
  int pend_due = -1;
  bit pend_nack = 1'b0;
  int busy_end = 0;
  int ign_start_at = -1;
  int stray_at = -1;

  int          obs_t [$];
  logic [15:0] obs_d [$];
  int          obs_r [$];
  int          exp_t [$];
  logic [15:0] exp_d [$];
  int          exp_r [$];
  bit          exp_err;
  int          exp_step;
  int          exp_retry;
  int          t_end;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int lookup(input logic [15:0] d);
    for (int i = 0; i < 12; i++) if (tbl[i] == d) return i;
    return -1;
  endfunction

  function automatic void clear_policy();
    for (int i = 0; i < 12; i++) begin
      fails[i]  = 0;
      silent[i] = 1'b0;
    end
  endfunction

  // Transaction-level prediction: each attempt lasts lat (or WD if unanswered),
  // then gap plus two cycles to the next start.
  function automatic void build_model(input int t0, input int busy_b);
    int t;
    bit fail;
    exp_t.delete(); exp_d.delete(); exp_r.delete();
    exp_err = 1'b0; exp_step = 12; exp_retry = 0;
    t = t0 + ((busy_b + 1 > 2) ? busy_b + 1 : 2);
    for (int i = 0; i < 12; i++) begin
      for (int a = 0; a <= MAXR; a++) begin
        exp_t.push_back(t); exp_d.push_back(tbl[i]); exp_r.push_back(a);
        fail = (a < fails[i]);
        t += ((fail && silent[i]) ? WD : lat) + GAP + 2;
        if (!fail) break;
        if (a == MAXR) begin
          exp_err = 1'b1; exp_step = i; exp_retry = MAXR;
        end
      end
      if (exp_err) break;
    end
    t_end = t;
  endfunction

  // One clock: sample at the falling edge, then act as the I2C master.
  task automatic tick();
    int  k;
    bit  fail;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    bus.i2c_done    = 1'b0;
    bus.i2c_ack_err = 1'b0;
    start           = 1'b0;
    bus.i2c_busy    = (cyc < busy_end);
    if (!reset) begin
      pend_due = -1;
    end else if (bus.i2c_start === 1'b1) begin
      obs_t.push_back(cyc); obs_d.push_back(bus.i2c_data); obs_r.push_back(int'(retry_cnt));
      chk("dev_addr", {25'd0, bus.i2c_dev_addr}, 32'h1A);
      chk("busy_at_start", {31'd0, busy}, 32'd1);
      k = lookup(bus.i2c_data);
      fail = 1'b0;
      if (k >= 0) begin
        fail = (attempts[k] < fails[k]);
        attempts[k]++;
      end
      if (!(k >= 0 && fail && silent[k])) begin
        pend_due  = cyc + lat;
        pend_nack = fail;
      end
    end
    if (cyc == pend_due) begin
      bus.i2c_done = 1'b1; bus.i2c_ack_err = pend_nack; pend_due = -1;
    end
    if (cyc == stray_at) begin
      bus.i2c_done = 1'b1; bus.i2c_ack_err = 1'($urandom);
    end
    if (cyc == ign_start_at) start = 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    chk("rst_i2c_start", {31'd0, bus.i2c_start}, 32'd0);
    chk("rst_i2c_data", {16'd0, bus.i2c_data}, 32'h1E00);
    chk("rst_dev_addr", {25'd0, bus.i2c_dev_addr}, 32'h1A);
    chk("rst_step", {28'd0, step}, 32'd0);
    chk("rst_retry_cnt", {30'd0, retry_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    chk("rst_cfg_error", {31'd0, cfg_error}, 32'd0);
    tick();
  endtask

  task automatic run_seq(input bit by_start, input int busy_b, input bit inject, input int abort_k);
    int t0;
    if (!by_start) apply_reset();
    for (int i = 0; i < 12; i++) attempts[i] = 0;
    obs_t.delete(); obs_d.delete(); obs_r.delete();
    t0 = cyc;
    build_model(t0, busy_b);
    ign_start_at = inject ? exp_t[2] + 3 : -1;
    stray_at     = inject ? exp_t[3] + lat + 2 : -1;
    busy_end     = t0 + busy_b;
    bus.i2c_busy = (busy_b > 0);
    if (by_start) begin
      start = 1'b1;
      tick();
      chk("restart_flags_clear", {30'd0, cfg_done, cfg_error}, 32'd0);
      chk("restart_busy", {31'd0, busy}, 32'd1);
    end else begin
      reset = 1'b1;
    end
    if (abort_k >= 0) begin
      while (cyc < exp_t[abort_k] + 3) tick();
      chk("abort_start_count", obs_t.size(), abort_k + 1);
      apply_reset();
      return;
    end
    while (cyc < t_end + 30) tick();
    chk("start_count", obs_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < obs_t.size(); i++) begin
      chk($sformatf("start%0d_cycle", i), obs_t[i], exp_t[i]);
      chk($sformatf("start%0d_data", i), {16'd0, obs_d[i]}, {16'd0, exp_d[i]});
      chk($sformatf("start%0d_retry", i), obs_r[i], exp_r[i]);
    end
    chk("end_cfg_done", {31'd0, cfg_done}, {31'd0, !exp_err});
    chk("end_cfg_error", {31'd0, cfg_error}, {31'd0, exp_err});
    chk("end_step", {28'd0, step}, exp_step);
    chk("end_busy", {31'd0, busy}, 32'd0);
    if (exp_err) chk("end_retry_cnt", {30'd0, retry_cnt}, exp_retry);
  endtask

  initial begin
    bus.i2c_busy    = 1'b0;
    bus.i2c_done    = 1'b0;
    bus.i2c_ack_err = 1'b0;

    // Nominal run, fixed 10-cycle responder.
    clear_policy();
    lat = 10;
    run_seq(1'b0, 0, 1'b0, -1);
    if (obs_t.size() > 1) chk("nominal_spacing", obs_t[1] - obs_t[0], 16);

    // Single NACK on the first attempt of entry 4.
    clear_policy();
    fails[4] = 1;
    lat = $urandom_range(5, 12);
    run_seq(1'b0, 0, 1'b0, -1);

    // Entry 7 always NACKs, then a start pulse restarts from the top.
    clear_policy();
    fails[7] = MAXR + 1;
    lat = $urandom_range(5, 12);
    run_seq(1'b0, 0, 1'b0, -1);
    clear_policy();
    run_seq(1'b1, 0, 1'b0, -1);

    // Entry 0 never answered.
    clear_policy();
    fails[0]  = MAXR + 1;
    silent[0] = 1'b1;
    run_seq(1'b0, 0, 1'b0, -1);

    // Busy held after reset, stray start in WAIT and stray done in GAP.
    clear_policy();
    lat = $urandom_range(5, 12);
    run_seq(1'b0, 20, 1'b1, -1);

    // Reset during WAIT at entry 5, then a clean full run.
    clear_policy();
    run_seq(1'b0, 0, 1'b0, 5);
    run_seq(1'b0, 0, 1'b0, -1);

    // Random fault mixes.
    repeat (4) begin
      clear_policy();
      for (int i = 0; i < 12; i++) begin
        fails[i]  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, MAXR + 1)) : 0;
        silent[i] = ($urandom_range(0, 3) == 0);
      end
      lat = $urandom_range(2, 20);
      run_seq(1'b0, $urandom_range(0, 6), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
